// File: rtl/seq_adder_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// seq_adder_pkg : state encoding and index sizing for seq_adder
// Rev 1.0
// ------------------------------------------------------------------
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index register width: clog2 of the chunk count, never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_adder_chunk_adder.sv
`default_nettype none
// ------------------------------------------------------------------
// chunk_adder : combinational W-bit ripple adder with carry in/out
// Rev 1.0
// ------------------------------------------------------------------
module chunk_adder #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] w_carry;

  always_comb begin
    w_carry    = '0;
    sum        = '0;
    w_carry[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ w_carry[i];
      w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end
    cout = w_carry[W];
  end

endmodule
`default_nettype wire

// File: rtl/seq_adder.sv
`default_nettype none
// ------------------------------------------------------------------
// seq_adder : multi-cycle adder, CHUNK bits per clock, valid/ready I/O
// Rev 1.0
// ------------------------------------------------------------------
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] c_last_idx = IW'(NCHUNK - 1);

  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("seq_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
    end
  endgenerate

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CHUNK-1:0] w_csum;
  logic             w_ccout;
  logic             w_accept;

  assign in_ready = (r_state == IDLE) || (r_state == DONE && out_ready);
  assign w_accept = in_ready && in_valid;

  chunk_adder #(.W(CHUNK)) u_chunk (
    .a    (r_a[r_idx*CHUNK +: CHUNK]),
    .b    (r_b[r_idx*CHUNK +: CHUNK]),
    .cin  (r_carry),
    .sum  (w_csum),
    .cout (w_ccout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          sum[r_idx*CHUNK +: CHUNK] <= w_csum;
          r_carry <= w_ccout;
          if (r_idx == c_last_idx) begin
            // The final chunk carries the sum MSB, so overflow is resolved here.
            r_state   <= DONE;
            out_valid <= 1'b1;
            cout      <= w_ccout;
            ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_csum[CHUNK-1] != r_a[WIDTH-1]);
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Accept overrides the DONE->IDLE move to give back-to-back operation.
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_idx   <= '0;
        r_state <= RUN;
      end
    end
  end

endmodule
`default_nettype wire
